// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared types and helpers for the NTT multiplier arbiter
package ntt_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int DEFAULT_DATA_W = 32;

  // Requester ID width; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at rr_ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_valid
);

  always_comb begin
    int idx;
    idx          = 0;
    grant_onehot = '0;
    grant_id     = '0;
    any_valid    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid         = 1'b1;
        grant_id          = ID_W'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ntt_mul_arbiter.sv
// rtl/ntt_mul_arbiter.sv - round-robin sharing of one sequential multiplier core
// Optional: NTT_MUL_ARB_TIMEOUT_EN adds a WAIT timeout and the rsp_err output.
module ntt_mul_arbiter
  import ntt_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ),
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [2*DATA_W-1:0]       rsp_prod,
  output logic                      mul_start,
  output logic [DATA_W-1:0]         mul_x,
  output logic [DATA_W-1:0]         mul_y,
  input  logic                      mul_done,
  input  logic [2*DATA_W-1:0]       mul_prod,
`ifdef NTT_MUL_ARB_TIMEOUT_EN
  output logic                      rsp_err,
`endif
  output logic                      busy
);

  if ((DATA_W % 2) != 0 || NUM_REQ < 2 || NUM_REQ > 16 ||
      ID_W != id_width(NUM_REQ) || TIMEOUT < 2) begin : g_param_check
    $error("ntt_mul_arbiter: illegal parameter combination");
  end

  state_t              state, state_next;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     id_q;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic [ID_W-1:0]     grant_id;
  logic                any_valid;
  logic                timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_valid    (req_valid),
    .rr_ptr       (rr_ptr),
    .grant_onehot (grant_onehot),
    .grant_id     (grant_id),
    .any_valid    (any_valid)
  );

`ifdef NTT_MUL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] wait_cnt;

  // Firing on TIMEOUT-2 puts rsp_valid exactly TIMEOUT cycles after mul_start.
  assign timeout_hit = (state == S_WAIT) && !mul_done && (wait_cnt == CNT_W'(TIMEOUT - 2));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      rsp_err  <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
      if (state == S_WAIT && mul_done)
        rsp_err <= 1'b0;
      else if (timeout_hit)
        rsp_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    mul_start  = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (!reset) req_ready = grant_onehot;
        if (any_valid) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        mul_start  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT:  if (mul_done || timeout_hit) state_next = S_RESP;
      S_RESP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      id_q      <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_prod  <= '0;
    end else begin
      case (state)
        S_IDLE: if (any_valid) begin
          mul_x  <= req_a[int'(grant_id)*DATA_W +: DATA_W];
          mul_y  <= req_b[int'(grant_id)*DATA_W +: DATA_W];
          id_q   <= grant_id;
          rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
        S_WAIT: if (mul_done || timeout_hit) begin
          rsp_prod  <= mul_done ? mul_prod : '1;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
        end
        S_RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
